add_bist_ctrl: RTL and testbench

ADD_BIST_CTRL -- requirements
Module: add_bist_ctrl

---
 rtl/add_bist_pkg.sv | 15 +
 rtl/add_bist_vecgen.sv | 40 ++++
 rtl/add_bist_ctrl.sv | 108 ++++++++++
 tb/tb_add_bist_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/add_bist_pkg.sv
// Shared types and sizes for the exhaustive 4-bit adder self-test controller.
package add_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OP_W    = 4;
    localparam int VEC_W   = 2 * OP_W;
    localparam int NUM_VEC = 256;
    localparam int ERR_W   = 9;

endpackage

// File: rtl/add_bist_vecgen.sv
// Vector counter with per-vector settle timer; strobe marks the last edge of each window.
module add_bist_vecgen
    import add_bist_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    output logic [VEC_W-1:0] k,
    output logic             strobe,
    output logic             last
);

    logic [3:0] cnt;

    assign strobe = en && (cnt == 4'd0);
    assign last   = (k == VEC_W'(NUM_VEC - 1));

    // k parks on the final vector so the operands hold (15,15) once the run ends
    always_ff @(posedge clk) begin
        if (clr) begin
            k   <= '0;
            cnt <= 4'(SETTLE);
        end else if (load) begin
            k   <= '0;
            cnt <= 4'(SETTLE);
        end else if (en) begin
            if (cnt == 4'd0) begin
                cnt <= 4'(SETTLE);
                if (!last)
                    k <= k + 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_bist_ctrl.sv
// Exhaustive self-test of an external 4-bit adder: walks all 256 operand pairs,
// counts mismatches and records the first failing vector.
module add_bist_ctrl
    import add_bist_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [OP_W-1:0]  num1,
    output logic [OP_W-1:0]  num2,
    input  logic [OP_W-1:0]  out,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [OP_W-1:0]  first_a,
    output logic [OP_W-1:0]  first_b,
    output logic [OP_W:0]    first_got
);

    state_t           state, nxt;
    logic [VEC_W-1:0] k;
    logic             strobe, last, load, clr;
    logic [OP_W:0]    got, ref_sum;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (c == ERR_W'(NUM_VEC)) ? c : c + 1'b1;
    endfunction

    assign load    = (state != RUN) && start && !abort;
    assign clr     = rst || abort;
    assign num1    = k[VEC_W-1:OP_W];
    assign num2    = k[OP_W-1:0];
    assign got     = {cout, out};
    assign ref_sum = {1'b0, num1} + {1'b0, num2};

    add_bist_vecgen #(.SETTLE(SETTLE)) u_vecgen (
        .clk    (clk),
        .clr    (clr),
        .load   (load),
        .en     (state == RUN),
        .k      (k),
        .strobe (strobe),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: begin
                if (abort)
                    nxt = IDLE;
                else if (start)
                    nxt = RUN;
            end
            RUN: begin
                if (abort)
                    nxt = IDLE;
                else if (strobe && last)
                    nxt = DONE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (state)
            RUN:  busy = 1'b1;
            DONE: begin
                done = 1'b1;
                pass = (err_count == '0);
            end
            default: ;
        endcase
    end

    // An aborting edge does not score the vector it lands on
    always_ff @(posedge clk) begin
        if (rst || load) begin
            err_count <= '0;
            first_a   <= '0;
            first_b   <= '0;
            first_got <= '0;
        end else if (strobe && !abort && (got != ref_sum)) begin
            err_count <= sat_inc(err_count);
            if (err_count == '0) begin
                first_a   <= num1;
                first_b   <= num2;
                first_got <= got;
            end
        end
    end

endmodule

// File: tb/tb_add_bist_ctrl.sv
// Bench for add_bist_ctrl: two instances (SETTLE=1 and SETTLE=0) each driving a faultable adder model.
module tb_add_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    int         vectors = 0;
    int         miscompares = 0;
    int         mode = 0;
    logic [4:0] xm [256];

    logic [3:0] num1_1, num2_1, out_1, fa_1, fb_1;
    logic [3:0] num1_0, num2_0, out_0, fa_0, fb_0;
    logic       cout_1, busy_1, done_1, pass_1;
    logic       cout_0, busy_0, done_0, pass_0;
    logic [8:0] err_1, err_0;
    logic [4:0] fg_1, fg_0;

    always #5 clk = ~clk;

    // Adder under test with selectable fault: 1 cout stuck 0, 2 out[0] stuck 0, 3 per-vector xor
    function automatic logic [4:0] aut(input logic [3:0] a, input logic [3:0] b,
                                       input int m, input logic [4:0] x);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (m)
            1: s[4] = 1'b0;
            2: s[0] = 1'b0;
            3: s = s ^ x;
            default: ;
        endcase
        return s;
    endfunction

    assign {cout_1, out_1} = aut(num1_1, num2_1, mode, xm[{num1_1, num2_1}]);
    assign {cout_0, out_0} = aut(num1_0, num2_0, mode, xm[{num1_0, num2_0}]);

    add_bist_ctrl #(.SETTLE(1)) d1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num1(num1_1), .num2(num2_1), .out(out_1), .cout(cout_1),
        .busy(busy_1), .done(done_1), .pass(pass_1), .err_count(err_1),
        .first_a(fa_1), .first_b(fb_1), .first_got(fg_1)
    );

    add_bist_ctrl #(.SETTLE(0)) d0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num1(num1_0), .num2(num2_0), .out(out_0), .cout(cout_0),
        .busy(busy_0), .done(done_0), .pass(pass_0), .err_count(err_0),
        .first_a(fa_0), .first_b(fb_0), .first_got(fg_0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk operand pairs (a outer, b inner) below lim and tally mismatches
    task automatic model(input int lim, output int e, output int fa, output int fb, output int fg);
        logic [4:0] g;
        e = 0; fa = 0; fb = 0; fg = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                if (a * 16 + b < lim) begin
                    g = aut(4'(a), 4'(b), mode, xm[8'(a * 16 + b)]);
                    if (int'(g) != a + b) begin
                        if (e == 0) begin
                            fa = a; fb = b; fg = int'(g);
                        end
                        e++;
                    end
                end
        if (e > 256) e = 256;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy1"}, 32'(busy_1), 0);
        chk({tag, "_done1"}, 32'(done_1), 0);
        chk({tag, "_pass1"}, 32'(pass_1), 0);
        chk({tag, "_err1"},  32'(err_1), 0);
        chk({tag, "_first1"}, 32'({fa_1, fb_1, fg_1}), 0);
        chk({tag, "_num1"},  32'({num1_1, num2_1}), 0);
        chk({tag, "_all0"},  32'({busy_0, done_0, pass_0, err_0, fa_0, fb_0, fg_0, num1_0, num2_0}), 0);
    endtask

    task automatic run_full(input string tag);
        int e, fa, fb, fg, lat0, lat1;
        model(256, e, fa, fb, fg);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_clr_busy"}, 32'(busy_1), 1);
        chk({tag, "_clr_done"}, 32'(done_1), 0);
        chk({tag, "_clr_err"},  32'(err_1 + err_0), 0);
        chk({tag, "_clr_first"}, 32'({fa_1, fb_1, fg_1}), 0);
        lat0 = 0; lat1 = 0;
        for (int c = 1; c <= 700 && lat1 == 0; c++) begin
            step();
            if (done_0 && lat0 == 0) lat0 = c;
            if (done_1 && lat1 == 0) lat1 = c;
        end
        chk({tag, "_lat_s0"}, 32'(lat0), 256);
        chk({tag, "_lat_s1"}, 32'(lat1), 512);
        chk({tag, "_err1"}, 32'(err_1), 32'(e));
        chk({tag, "_err0"}, 32'(err_0), 32'(e));
        chk({tag, "_fa1"},  32'(fa_1), 32'(fa));
        chk({tag, "_fb1"},  32'(fb_1), 32'(fb));
        chk({tag, "_fg1"},  32'(fg_1), 32'(fg));
        chk({tag, "_first0"}, 32'({fa_0, fb_0, fg_0}), 32'({4'(fa), 4'(fb), 5'(fg)}));
        chk({tag, "_pass1"}, 32'(pass_1), 32'(e == 0));
        chk({tag, "_pass0"}, 32'(pass_0), 32'(e == 0));
        chk({tag, "_busy"}, 32'({busy_1, busy_0}), 0);
        chk({tag, "_num_last"}, 32'({num1_1, num2_1, num1_0, num2_0}), 32'hFFFF);
        repeat (5) step();
        chk({tag, "_hold"}, 32'({done_1, err_1}), 32'({1'b1, 9'(e)}));
    endtask

    task automatic wait_k(input int v, input string tag);
        int c;
        c = 0;
        while ({num1_1, num2_1} != 8'(v) && c < 1000) begin
            step();
            c++;
        end
        chk(tag, 32'({num1_1, num2_1}), 32'(v));
    endtask

    initial begin
        int e, fa, fb, fg, seen;
        foreach (xm[i]) xm[i] = 5'd0;
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        step();

        mode = 0;
        run_full("good");
        mode = 1;
        run_full("cout_stuck");
        chk("cout_stuck_n120", 32'(err_1), 120);
        mode = 2;
        run_full("out0_stuck");
        chk("out0_stuck_n128", 32'(err_1), 128);
        mode = 0;
        run_full("good_restart");

        mode = 3;
        for (int r = 0; r < 3; r++) begin
            foreach (xm[i]) xm[i] = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            run_full($sformatf("rand%0d", r));
        end
        foreach (xm[i]) xm[i] = 5'($urandom_range(1, 31));
        run_full("all_bad");

        // start while running must not disturb k; abort at k=10 keeps partial results
        mode = 2;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_k(3, "reach_k3");
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_run_k", 32'({num1_1, num2_1}), 3);
        chk("start_in_run_busy", 32'(busy_1), 1);
        wait_k(10, "reach_k10");
        abort = 1'b1;
        step();
        abort = 1'b0;
        model(10, e, fa, fb, fg);
        chk("abort_busy_done", 32'({busy_1, done_1, busy_0}), 0);
        chk("abort_num", 32'({num1_1, num2_1}), 0);
        chk("abort_err_kept", 32'(err_1), 32'(e));
        chk("abort_first_kept", 32'({fa_1, fb_1, fg_1}), 32'({4'(fa), 4'(fb), 5'(fg)}));
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", 32'({busy_1, done_1, num1_1, num2_1}), 0);
        step();
        chk("idle_stays", 32'({busy_1, busy_0}), 0);

        // reset mid-run discards everything and no done follows
        mode = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_k(100, "reach_k100");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("midrun_rst");
        seen = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            if (done_1 || done_0 || busy_1 || busy_0) seen = 1;
        end
        chk("no_done_after_rst", 32'(seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
